// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM controller.
// Each access is IDLE -> ACCESS (until sram_ready or timeout) -> RECOVER -> IDLE.
module sram_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_addr,
  output logic              write_data,
  output logic              read_data,
  input  logic [DATA_W-1:0] data_out,
  input  logic              sram_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  // state   | meaning
  // IDLE    | no access; requests sampled each edge
  // ACCESS  | command driven, waiting for sram_ready or timeout
  // RECOVER | one dead cycle carrying the ack pulse
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win1;

  // Requester 1 wins when alone, or on contention when 0 was granted last.
  assign win1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          state_d = ACCESS;
          wr_d    = win1 ? req1_write : req0_write;
          rd_d    = ~(win1 ? req1_write : req0_write);
          addr_d  = win1 ? req1_addr : req0_addr;
          wdata_d = win1 ? req1_wdata : req0_wdata;
          grant_d = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (sram_ready) begin
          state_d = RECOVER;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          grant_d = 2'b00;
          ack_d   = grant_q;
          if (rd_q) begin
            if (grant_q[1]) rdata1_d = data_out;
            else            rdata0_d = data_out;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = RECOVER;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          grant_d = 2'b00;
          ack_d   = grant_q;
          err_d   = grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign write_data = wr_q;
  assign read_data  = rd_q;
  assign data_addr  = addr_q;
  assign data_in    = wdata_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign req0_ack   = ack_q[0];
  assign req1_ack   = ack_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin / memory model.
module tb_sram_arbiter;

  localparam int TOUT = 1023;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [15:0] wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [20:0] req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ack, req0_err, req1_ack, req1_err;
  logic [15:0] req0_rdata, req1_rdata;
  logic [15:0] data_in;
  logic [20:0] data_addr;
  logic        write_data, read_data;
  logic [15:0] data_out;
  logic        sram_ready;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .data_in(data_in), .data_addr(data_addr), .write_data(write_data),
    .read_data(read_data), .data_out(data_out), .sram_ready(sram_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    data_out = '0; sram_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req0_valid = 1; sram_ready = 1; data_out = 16'hFFFF;
    do_reset();
    checks++;
    if ({write_data, read_data, data_addr, data_in, grant, busy} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: wr=%b rd=%b addr=%h din=%h grant=%b busy=%b, required all 0",
               write_data, read_data, data_addr, data_in, grant, busy);
    end
    checks++;
    if ({req0_ack, req0_err, req1_ack, req1_err, req0_rdata, req1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_req: ack=%b%b err=%b%b rdata0=%h rdata1=%h, required all 0",
               req1_ack, req0_ack, req1_err, req0_err, req0_rdata, req1_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    clear_inputs();
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addr = 21'h0; req0_wdata = 16'h8AF5;
    tick();
    checks++;
    if ({write_data, read_data, data_addr, data_in, grant, busy} !==
        {1'b1, 1'b0, 21'h0, 16'h8AF5, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL write_issue: wr=%b rd=%b addr=%h din=%h grant=%b busy=%b, required 1 0 0 8af5 01 1",
               write_data, read_data, data_addr, data_in, grant, busy);
    end
    tick();
    checks++;
    if ({write_data, data_in, req0_ack} !== {1'b1, 16'h8AF5, 1'b0}) begin
      errors++;
      $display("FAIL write_hold: wr=%b din=%h ack0=%b, required 1 8af5 0", write_data, data_in, req0_ack);
    end
    sram_ready = 1;
    tick();
    sram_ready = 0;
    checks++;
    if ({write_data, read_data, req0_ack, req0_err, req1_ack} !== 5'b00100) begin
      errors++;
      $display("FAIL write_ack: wr=%b rd=%b ack0=%b err0=%b ack1=%b, required 0 0 1 0 0",
               write_data, read_data, req0_ack, req0_err, req1_ack);
    end
    req0_valid = 0;
    tick();
    checks++;
    if ({req0_ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL write_after_ack: ack0=%b busy=%b, required 0 0", req0_ack, busy);
    end
    tick();
    checks++;
    if ({busy, write_data} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle: busy=%b wr=%b, required 0 0", busy, write_data);
    end
  endtask

  task automatic test_read();
    logic [15:0] r0_before;
    clear_inputs();
    r0_before = req0_rdata;
    req1_valid = 1; req1_write = 0; req1_addr = 21'h1F;
    tick();
    checks++;
    if ({read_data, write_data, data_addr, grant} !== {1'b1, 1'b0, 21'h1F, 2'b10}) begin
      errors++;
      $display("FAIL read_issue: rd=%b wr=%b addr=%h grant=%b, required 1 0 1f 10",
               read_data, write_data, data_addr, grant);
    end
    sram_ready = 1; data_out = 16'hBEEF;
    tick();
    sram_ready = 0; data_out = 16'h0;
    checks++;
    if ({req1_ack, req1_err, req0_ack, read_data, req1_rdata} !== {4'b1000, 16'hBEEF}) begin
      errors++;
      $display("FAIL read_ack: ack1=%b err1=%b ack0=%b rd=%b rdata1=%h, required 1 0 0 0 beef",
               req1_ack, req1_err, req0_ack, read_data, req1_rdata);
    end
    checks++;
    if (req0_rdata !== r0_before) begin
      errors++;
      $display("FAIL read_other: rdata0=%h, required %h", req0_rdata, r0_before);
    end
    req1_valid = 0;
    tick();
    tick();
    checks++;
    if (req1_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_hold: rdata1=%h, required beef", req1_rdata);
    end
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] exp_g;
    clear_inputs();
    req0_valid = 1; req0_addr = 21'h10;
    req1_valid = 1; req1_addr = 21'h20;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (!(read_data | write_data) && n < 6) begin
        tick();
        n++;
      end
      checks++;
      if ({grant, n} !== {exp_g, ((i == 0) ? 1 : 2)}) begin
        errors++;
        $display("FAIL contention_grant%0d: grant=%b after %0d cycles, required %b after %0d",
                 i, grant, n, exp_g, (i == 0) ? 1 : 2);
      end
      sram_ready = 1; data_out = 16'h1000 + 16'(i);
      tick();
      sram_ready = 0;
      checks++;
      if ({read_data, write_data, req1_ack, req0_ack} !== {2'b00, exp_g}) begin
        errors++;
        $display("FAIL contention_recover%0d: rd=%b wr=%b ack=%b%b, required 0 0 %b",
                 i, read_data, write_data, req1_ack, req0_ack, exp_g);
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic run_timeout(input bit ready_last, input logic [15:0] exp_rd);
    int n;
    clear_inputs();
    req0_valid = 1; req0_write = 0; req0_addr = 21'h5;
    data_out = 16'h5A5A;
    tick();
    n = 0;
    while ((read_data | write_data) && n < 2 * TOUT) begin
      n++;
      if (ready_last && n == TOUT) sram_ready = 1;
      tick();
    end
    sram_ready = 0;
    checks++;
    if (n !== TOUT) begin
      errors++;
      $display("FAIL timeout_len: command high %0d cycles, required %0d", n, TOUT);
    end
    checks++;
    if ({req0_ack, req0_err, req1_ack, req0_rdata} !== {1'b1, !ready_last, 1'b0, exp_rd}) begin
      errors++;
      $display("FAIL timeout_ack: ack0=%b err0=%b ack1=%b rdata0=%h, required 1 %b 0 %h",
               req0_ack, req0_err, req1_ack, req0_rdata, !ready_last, exp_rd);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    do_reset();
    req0_valid = 1; req0_write = 0; req0_addr = 21'h5;
    tick();
    sram_ready = 1; data_out = 16'h1234;
    tick();
    clear_inputs();
    checks++;
    if ({req0_ack, req0_rdata} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL timeout_pre: ack0=%b rdata0=%h, required 1 1234", req0_ack, req0_rdata);
    end
    tick();
    tick();
    run_timeout(1'b0, 16'h1234);
    run_timeout(1'b1, 16'h5A5A);
  endtask

  task automatic test_reset_mid_access();
    clear_inputs();
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addr = 21'h7; req0_wdata = 16'h0F0F;
    tick();
    tick();
    tick();
    reset = 1;
    tick();
    checks++;
    if ({read_data, write_data, grant, req0_ack, req1_ack, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_abort: rd=%b wr=%b grant=%b ack=%b%b busy=%b, required all 0",
               read_data, write_data, grant, req1_ack, req0_ack, busy);
    end
    reset = 0;
    req1_valid = 1; req1_write = 1;
    tick();
    checks++;
    if ({grant, write_data, req0_ack, req1_ack} !== {2'b01, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL midreset_regrant: grant=%b wr=%b ack=%b%b, required 01 1 00",
               grant, write_data, req1_ack, req0_ack);
    end
    sram_ready = 1;
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur;
    txn_t t;
    int   last_w, exp_w, cur_w, lat, acc_n, since_ack, done_n, total, budget;
    logic in_acc;
    logic [15:0] exp_rd;
    clear_inputs();
    do_reset();
    sram_mem.delete();
    ref_mem.delete();
    for (int i = 0; i < 32; i++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.addr = 21'($urandom_range(0, 7));
      t.wd = 16'($urandom);
      if (i < 12) q0.push_back(t);
      else        q1.push_back(t);
    end
    total = 32; done_n = 0; last_w = 1; cur_w = 0; exp_w = 0;
    lat = 1; acc_n = 0; since_ack = -1; in_acc = 0; budget = 3000;
    cur = '0;
    req0_valid = 1; {req0_write, req0_addr, req0_wdata} = q0[0];
    req1_valid = 1; {req1_write, req1_addr, req1_wdata} = q1[0];
    while (done_n < total && budget > 0) begin
      tick();
      budget--;
      if (since_ack >= 0) since_ack++;
      checks++;
      if (req0_ack && req1_ack) begin
        errors++;
        $display("FAIL rand_dual_ack: both acks high");
      end
      if (write_data | read_data) begin
        if (!in_acc) begin
          in_acc = 1; acc_n = 1;
          lat = $urandom_range(1, 6);
          if (q0.size() > 0 && q1.size() > 0) exp_w = 1 - last_w;
          else exp_w = (q0.size() > 0) ? 0 : 1;
          cur = (exp_w == 1) ? q1[0] : q0[0];
          cur_w = exp_w;
          checks++;
          if ({grant, write_data, read_data, data_addr} !==
              {((exp_w == 1) ? 2'b10 : 2'b01), cur.wr, !cur.wr, cur.addr} ||
              (cur.wr && data_in !== cur.wd)) begin
            errors++;
            $display("FAIL rand_issue: grant=%b wr=%b rd=%b addr=%h din=%h, required req%0d wr=%b addr=%h din=%h",
                     grant, write_data, read_data, data_addr, data_in, exp_w, cur.wr, cur.addr, cur.wd);
          end
          if (since_ack >= 0) begin
            checks++;
            if (since_ack != 2) begin
              errors++;
              $display("FAIL rand_gap: command %0d cycles after ack, required 2", since_ack);
            end
          end
        end else begin
          acc_n++;
          checks++;
          if ({data_addr, grant} !== {cur.addr, ((cur_w == 1) ? 2'b10 : 2'b01)}) begin
            errors++;
            $display("FAIL rand_stable: addr=%h grant=%b, required %h req%0d", data_addr, grant, cur.addr, cur_w);
          end
        end
        sram_ready = (acc_n == lat);
        data_out = sram_mem.exists(int'(data_addr)) ? sram_mem[int'(data_addr)] : 16'h0000;
        if (sram_ready && write_data) sram_mem[int'(data_addr)] = data_in;
      end else begin
        sram_ready = 0;
        if (in_acc) begin
          in_acc = 0;
          checks++;
          if (acc_n != lat || {req1_ack, req0_ack} !== ((cur_w == 1) ? 2'b10 : 2'b01) ||
              {req1_err, req0_err} !== 2'b00) begin
            errors++;
            $display("FAIL rand_ack: len=%0d ack=%b%b err=%b%b, required len=%0d req%0d err 00",
                     acc_n, req1_ack, req0_ack, req1_err, req0_err, lat, cur_w);
          end
          if (!cur.wr) begin
            exp_rd = ref_mem.exists(int'(cur.addr)) ? ref_mem[int'(cur.addr)] : 16'h0000;
            checks++;
            if (((cur_w == 1) ? req1_rdata : req0_rdata) !== exp_rd) begin
              errors++;
              $display("FAIL rand_rdata: req%0d rdata=%h, required %h", cur_w,
                       (cur_w == 1) ? req1_rdata : req0_rdata, exp_rd);
            end
          end else begin
            ref_mem[int'(cur.addr)] = cur.wd;
          end
          last_w = cur_w;
          if (cur_w == 1) void'(q1.pop_front());
          else            void'(q0.pop_front());
          done_n++;
          since_ack = 0;
          req0_valid = (q0.size() > 0);
          if (q0.size() > 0) {req0_write, req0_addr, req0_wdata} = q0[0];
          req1_valid = (q1.size() > 0);
          if (q1.size() > 0) {req1_write, req1_addr, req1_wdata} = q1[0];
        end
      end
    end
    checks++;
    if (done_n != total) begin
      errors++;
      $display("FAIL rand_done: completed %0d transactions, required %0d", done_n, total);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
